// File: rtl/pipelined_cla_subtractor.sv
// Two-stage pipelined subtractor D = A + ~B + 1 built from 4-bit carry look-ahead groups.
// Stage 1 resolves the lower half and the carry into the upper half; stage 2 finishes the upper half, BO and V.
module pipelined_cla_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             V
);

  localparam int H  = WIDTH / 2;
  localparam int NG = H / 4;

  // Half-width adder: group G/P per 4-bit group, every carry expanded as a sum of products.
  function automatic logic [H:0] cla_add(input logic [H-1:0] a, input logic [H-1:0] b,
                                         input logic cin);
    logic [H-1:0]  g, p, s;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          c, pp;
    g = a & b;
    p = a ^ b;
    s = '0;
    for (int k = 0; k < NG; k++) begin
      gg[k] = 1'b0;
      pp    = 1'b1;
      for (int j = 3; j >= 0; j--) begin
        gg[k] = gg[k] | (pp & g[4*k+j]);
        pp    = pp & p[4*k+j];
      end
      gp[k] = pp;
    end
    for (int k = 0; k <= NG; k++) begin
      c  = 1'b0;
      pp = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        c  = c | (pp & gg[j]);
        pp = pp & gp[j];
      end
      gc[k] = c | (pp & cin);
    end
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        c  = 1'b0;
        pp = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          c  = c | (pp & g[4*k+j]);
          pp = pp & p[4*k+j];
        end
        c          = c | (pp & gc[k]);
        s[4*k+i]   = p[4*k+i] ^ c;
      end
    end
    return {gc[NG], s};
  endfunction

  logic             adv1, adv2;
  logic [WIDTH-1:0] b_inv;
  logic [H:0]       lo_sum, hi_sum;
  logic             ovf;

  logic             s1_valid;
  logic [H-1:0]     s1_d_lo;
  logic             s1_c;
  logic [H-1:0]     s1_a_hi;
  logic [H-1:0]     s1_nb_hi;

  assign adv2     = !out_valid | out_ready;
  assign adv1     = !s1_valid | adv2;
  assign in_ready = adv1;

  // Stage 1: lower half with carry-in 1 (two's complement of B)
  assign b_inv  = ~B;
  assign lo_sum = cla_add(A[H-1:0], b_inv[H-1:0], 1'b1);

  // Stage 2: upper half driven by the registered inter-stage carry
  assign hi_sum = cla_add(s1_a_hi, s1_nb_hi, s1_c);
  assign ovf    = (s1_a_hi[H-1] ^ ~s1_nb_hi[H-1]) & (hi_sum[H-1] ^ s1_a_hi[H-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_d_lo   <= '0;
      s1_c      <= 1'b0;
      s1_a_hi   <= '0;
      s1_nb_hi  <= '0;
      out_valid <= 1'b0;
      D         <= '0;
      BO        <= 1'b0;
      V         <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_d_lo  <= lo_sum[H-1:0];
          s1_c     <= lo_sum[H];
          s1_a_hi  <= A[WIDTH-1:H];
          s1_nb_hi <= b_inv[WIDTH-1:H];
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          D  <= {hi_sum[H-1:0], s1_d_lo};
          BO <= ~hi_sum[H];
          V  <= ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Scoreboard bench for pipelined_cla_subtractor: expectations queued on accept, compared on drain.
module tb_pipelined_cla_subtractor;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, BO, V;
  logic [W-1:0] A, B, D;

  always #5 clk = ~clk;

  pipelined_cla_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .BO(BO), .V(V)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         v;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t         q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           ncyc  = 0;
  logic [W-1:0] cur_d;
  logic         cur_bo, cur_v;
  bit           cur_lat;
  bit           rand_on;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic bo, output logic v);
    d  = a - b;
    bo = (a < b);
    v  = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check_val("spurious_out", 64'(out_valid), 64'(0));
        else begin
          e = q.pop_front();
          check_val("D", 64'(D), 64'(e.d));
          check_val("BO", 64'(BO), 64'(e.bo));
          check_val("V", 64'(V), 64'(e.v));
          if (e.lat) check_val("latency", 64'(ncyc - e.cyc), 64'(2));
        end
      end
      if (in_valid && in_ready) begin
        e.d = cur_d; e.bo = cur_bo; e.v = cur_v; e.cyc = ncyc; e.lat = cur_lat;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d,
                      input logic bo, input logic v, input bit lat, output int waited);
    logic acc;
    A = a; B = b; in_valid = 1'b1;
    cur_d = d; cur_bo = bo; cur_v = v; cur_lat = lat;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) waited++;
    end
    if (!acc) check_val("accept_timeout", 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [W-1:0] ta [6] = '{32'h00000003, 32'h80000000, 32'hFFFFFFFF,
                           32'h00010000, 32'hA0A0FFFF, 32'h12345678};
  logic [W-1:0] tb [6] = '{32'h0000000A, 32'h00000001, 32'hFFFFFFFF,
                           32'h00000001, 32'hA0BFFFE0, 32'h12345678};
  logic [W-1:0] td [6] = '{32'hFFFFFFF9, 32'h7FFFFFFF, 32'h00000000,
                           32'h0000FFFF, 32'hFFE1001F, 32'h00000000};
  logic         tbo[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic         tv [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           w;
    logic [W-1:0] ra, rb, rd, d0;
    logic         rbo, rv;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; rand_on = 1'b0;
    cur_d = '0; cur_bo = 1'b0; cur_v = 1'b0; cur_lat = 1'b0;
    #12;
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_D", 64'(D), 64'(0));
    check_val("rst_BO", 64'(BO), 64'(0));
    check_val("rst_V", 64'(V), 64'(0));
    check_val("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'h0000000A, 32'h00000003, 32'h00000007, 1'b0, 1'b0, 1'b1, w);
    idle(4);

    for (int i = 0; i < 6; i++) begin
      send(ta[i], tb[i], td[i], tbo[i], tv[i], 1'b1, w);
      check_val("b2b_ready", 64'(w), 64'(0));
    end
    idle(5);

    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          ra = $urandom;
          rb = (i % 5 == 0) ? {ra[W-1:W/2], 16'($urandom)} : $urandom;
          model(ra, rb, rd, rbo, rv);
          send(ra, rb, rd, rbo, rv, 1'b0, w);
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    idle(6);

    out_ready = 1'b0;
    send(32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0, 1'b0, w);
    send(32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, w);
    A = 32'h7FFFFFFF; B = 32'hFFFFFFFF; in_valid = 1'b1;
    model(A, B, cur_d, cur_bo, cur_v);
    d0 = 32'h000000FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp_in_ready", 64'(in_ready), 64'(0));
      check_val("bp_out_valid", 64'(out_valid), 64'(1));
      check_val("bp_D_hold", 64'(D), 64'(d0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0, w);
    check_val("bp_third_wait", 64'(w), 64'(0));
    idle(5);

    send(32'h00005555, 32'h00001111, 32'h00004444, 1'b0, 1'b0, 1'b0, w);
    send(32'h00000009, 32'h00000004, 32'h00000005, 1'b0, 1'b0, 1'b0, w);
    check_val("pre_reset_valid", 64'(out_valid), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 64'(out_valid), 64'(0));
    check_val("midrst_D", 64'(D), 64'(0));
    check_val("midrst_in_ready", 64'(in_ready), 64'(1));
    #1 rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("post_rst_quiet", 64'(out_valid), 64'(0));
    end

    idle(2);
    check_val("leftover", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_subtractor.md
PIPELINED_CLA_SUBTRACTOR -- requirements
Module: pipelined_cla_subtractor

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a multiple of 8 (two halves, each built from 4-bit look-ahead groups).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair A/B presented.
REQ-005 in_ready  output  1  block accepts A/B this cycle.
REQ-006 A  input  WIDTH  minuend.
REQ-007 B  input  WIDTH  subtrahend.
REQ-008 out_valid  output  1  result D/BO/V valid.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 D  output  WIDTH  difference A-B modulo 2^WIDTH.
REQ-011 BO  output  1  borrow out; 1 iff A < B unsigned.
REQ-012 V  output  1  signed overflow of A-B (two's complement).

Function
REQ-013 Arithmetic SHALL be D = A + ~B + 1 using 4-bit carry look-ahead groups with group generate/propagate; no ripple chain longer than one group inside a stage.
REQ-014 BO SHALL equal the inverse of the final carry out; V SHALL be 1 iff A[MSB] != B[MSB] and D[MSB] != A[MSB].
REQ-015 Stage 1 SHALL compute the lower WIDTH/2 bits of D and the carry into the upper half, and register them together with A and ~B upper halves and a valid bit s1_valid.
REQ-016 Stage 2 SHALL compute the upper WIDTH/2 bits, BO and V from stage-1 registers and register D, BO, V, out_valid.
REQ-017 Latency SHALL be exactly 2 clock edges from an accepted input (in_valid & in_ready) to out_valid=1 for that result, absent backpressure.
REQ-018 Throughput SHALL be one operation per cycle when out_ready is held 1.
REQ-019 Stage 2 advances when adv2 = !out_valid | out_ready; stage 1 advances when adv1 = !s1_valid | adv2.
REQ-020 in_ready SHALL equal adv1 (combinational); inputs are accepted only when in_valid & in_ready.
REQ-021 While out_valid=1 and out_ready=0, D, BO, V and out_valid SHALL hold stable; stage 1 holds if also full; no result dropped or duplicated.
REQ-022 If stage 2 advances with s1_valid=0, out_valid SHALL fall to 0 on that edge (bubble propagates).
REQ-023 Simultaneous accept at input and drain at output in one cycle SHALL both occur; results exit in acceptance order.
REQ-024 Upper-half arithmetic SHALL use the registered inter-stage carry, so a borrow crossing bit WIDTH/2 is correct.
REQ-025 in_ready SHALL NOT depend on in_valid (no combinational loop).

Reset
REQ-026 rst_n=0 SHALL asynchronously clear s1_valid and out_valid to 0 and D, BO, V and all stage-1 data to 0.
REQ-027 During reset in_ready SHALL be 1; first accept possible on the first rising edge after rst_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight results; none appear after release.

Verification
REQ-029 Basic: A=0x0000000A, B=0x00000003, out_ready=1 -> two edges later out_valid=1, D=0x00000007, BO=0, V=0.
REQ-030 Borrow/overflow: A=0x00000003,B=0x0000000A -> D=0xFFFFFFF9,BO=1,V=0; A=0x80000000,B=0x00000001 -> D=0x7FFFFFFF,BO=0,V=1; A=B=0xFFFFFFFF -> D=0,BO=0,V=0.
REQ-031 Half-boundary borrow: A=0x00010000, B=0x00000001 -> D=0x0000FFFF, BO=0; A=0xA0A0FFFF,B=0xA0BFFFE0 -> D=0xFFE1001F, BO=1, V=0.
REQ-032 Back-to-back: 4 operands on consecutive cycles, out_ready=1 -> 4 results on 4 consecutive cycles, in order, in_ready stays 1.
REQ-033 Backpressure: out_ready=0 with 3 operands offered -> 2 accepted, in_ready=0 thereafter, D held stable; out_ready=1 -> results drain in order, third accepted.
REQ-034 Reset mid-flight: 2 operations in pipeline, pulse rst_n low between edges -> out_valid=0 and D=0 immediately, no result emitted after release.
